// File: rtl/rgbw_spi_master_if.sv
// Host-side bundle for the RGBW lamp SPI transmitter.
//   start, *_in : frame request and the seven command bytes (host -> transmitter)
//   busy, done  : frame status (transmitter -> host)
//   sck/mosi/cs : SPI mode-0 wire signals (transmitter -> lamp)
// modport master : the transmitter side; modport slave : host/harness side.
interface rgbw_spi_master_if;
  logic       start;
  logic [7:0] mode_in;
  logic [7:0] lint_in;
  logic [7:0] color_idx_in;
  logic [7:0] white_in;
  logic [7:0] red_in;
  logic [7:0] green_in;
  logic [7:0] blue_in;
  logic       busy;
  logic       done;
  logic       sck;
  logic       mosi;
  logic       cs;

  modport master (
    input  start, mode_in, lint_in, color_idx_in, white_in, red_in, green_in, blue_in,
    output busy, done, sck, mosi, cs
  );

  modport slave (
    output start, mode_in, lint_in, color_idx_in, white_in, red_in, green_in, blue_in,
    input  busy, done, sck, mosi, cs
  );
endinterface

// File: rtl/rgbw_spi_master.sv
// SPI mode-0 transmitter for the 7-byte lamp command frame
// (mode, lint, colorIdx, white, red, green, blue), each byte MSB first.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : rgbw_spi_master_if.master (start, byte inputs, busy, done, sck, mosi, cs)
// Parameters:
//   CLK_DIV    : sck half-period in clk cycles (2..255)
//   GAP_CYCLES : idle cycles between bytes with cs low and sck low (0 allowed)
// Frame length from the accepting edge to cs rising:
//   CLK_DIV + 7*16*CLK_DIV + 6*GAP_CYCLES + CLK_DIV cycles.
module rgbw_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  rgbw_spi_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  // With no inter-byte gap the next byte starts shifting on the byte-end edge.
  localparam state_t AFTER_BYTE = (GAP_CYCLES > 0) ? GAP : SHIFT;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [2:0]    byte_cnt, byte_cnt_n;
  // Remaining frame bits after the one currently on mosi; shifts out of bit 54.
  logic [54:0]   shadow, shadow_n;
  logic          sck_q, sck_n;
  logic          mosi_q, mosi_n;
  logic          cs_q, cs_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          div_end;

  assign div_end = (cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shadow   <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      shadow   <= shadow_n;
      sck_q    <= sck_n;
      mosi_q   <= mosi_n;
      cs_q     <= cs_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    shadow_n   = shadow;
    sck_n      = sck_q;
    mosi_n     = mosi_q;
    cs_n       = cs_q;
    busy_n     = busy_q;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.start) begin
          shadow_n   = {bus.mode_in[6:0], bus.lint_in, bus.color_idx_in, bus.white_in,
                        bus.red_in, bus.green_in, bus.blue_in};
          mosi_n     = bus.mode_in[7];
          cs_n       = 1'b0;
          busy_n     = 1'b1;
          bit_cnt_n  = '0;
          byte_cnt_n = '0;
          state_n    = SETUP;
        end
      end

      SETUP: begin
        if (div_end) begin
          cnt_n   = '0;
          state_n = SHIFT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      SHIFT: begin
        if (div_end) begin
          cnt_n = '0;
          sck_n = ~sck_q;
          if (sck_q) begin
            // Falling edge: advance to the next bit unless the frame is over.
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && byte_cnt == 3'd6) begin
              state_n = HOLD;
            end else begin
              shadow_n = {shadow[53:0], 1'b0};
              mosi_n   = shadow[54];
              if (bit_cnt == 3'd7) begin
                byte_cnt_n = byte_cnt + 3'd1;
                state_n    = AFTER_BYTE;
              end
            end
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = SHIFT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      HOLD: begin
        if (div_end) begin
          cnt_n   = '0;
          cs_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          mosi_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.cs   = cs_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_rgbw_spi_master.sv
// Bench for rgbw_spi_master: default-parameter instance (a) and a
// CLK_DIV=2 / GAP_CYCLES=0 instance (b), each with a mode-0 slave model.
module tb_rgbw_spi_master;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  always #5 clk = ~clk;

  rgbw_spi_master_if if_a ();
  rgbw_spi_master_if if_b ();

  rgbw_spi_master dut_a (.clk(clk), .reset(reset_a), .bus(if_a));
  rgbw_spi_master #(.CLK_DIV(2), .GAP_CYCLES(0)) dut_b (.clk(clk), .reset(reset_b), .bus(if_b));

  typedef struct {
    logic [55:0] din;
    logic [55:0] dexp;
    int          exp_cs_low;
    int          exp_rises;
  } vec_t;

  localparam logic [55:0] BASIC    = 56'h01FF3C80A55A0F;
  localparam logic [55:0] ALL55    = 56'h55555555555555;
  localparam logic [55:0] RST_DATA = 56'h112233FF556677;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- slave model / monitors, instance a ----------------
  logic [55:0] rx_a = '0;
  int rises_a = 0, cslow_a = 0, done_total_a = 0, prot_viol_a = 0;
  logic cs_prev_a = 1'b1, sck_prev_a = 1'b0;

  always @(posedge if_a.sck) if (!if_a.cs) begin
    rx_a = {rx_a[54:0], if_a.mosi};
    rises_a++;
  end

  always @(negedge clk) begin
    if (!if_a.cs) cslow_a++;
    if (if_a.done) done_total_a++;
    if (!reset_a && ((if_a.cs && if_a.sck) ||
        ((if_a.cs != cs_prev_a) && (if_a.sck || sck_prev_a))))
      prot_viol_a++;
    cs_prev_a  = if_a.cs;
    sck_prev_a = if_a.sck;
  end

  // ---------------- slave model / monitors, instance b ----------------
  logic [55:0] rx_b = '0;
  int rises_b = 0, cslow_b = 0, cyc_b = 0, last_rise_b = -1, stab_b = 100;
  int setup_viol_b = 0, period_viol_b = 0;
  logic sck_prev_b = 1'b0, mosi_prev_b = 1'b0;

  always @(posedge if_b.sck) if (!if_b.cs) begin
    rx_b = {rx_b[54:0], if_b.mosi};
    rises_b++;
  end

  always @(negedge clk) begin
    cyc_b++;
    if (!if_b.cs) cslow_b++;
    if (if_b.sck && !sck_prev_b) begin
      if (stab_b < 2) setup_viol_b++;
      if (last_rise_b >= 0 && (cyc_b - last_rise_b) != 4) period_viol_b++;
      last_rise_b = cyc_b;
    end
    if (if_b.cs) last_rise_b = -1;
    if (if_b.mosi != mosi_prev_b) stab_b = 1;
    else stab_b++;
    mosi_prev_b = if_b.mosi;
    sck_prev_b  = if_b.sck;
  end

  // ---------------- driver tasks for instance a ----------------
  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic start_a(input logic [55:0] d);
    {if_a.mode_in, if_a.lint_in, if_a.color_idx_in, if_a.white_in,
     if_a.red_in, if_a.green_in, if_a.blue_in} = d;
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
  endtask

  task automatic wait_done_a(output bit ok, output int drops);
    ok = 1'b0;
    drops = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_a.done) begin
        ok = 1'b1;
        break;
      end
      if (!if_a.busy) drops++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int cs0, r0, drops;
    bit ok;
    cs0 = cslow_a;
    r0  = rises_a;
    start_a(v.din);
    wait_done_a(ok, drops);
    chk({nm, "_done_seen"}, 64'(ok), 64'd1);
    chk({nm, "_busy_at_done"}, 64'(if_a.busy), 64'd0);
    chk({nm, "_cs_low_cycles"}, 64'(cslow_a - cs0), 64'(v.exp_cs_low));
    chk({nm, "_sck_rises"}, 64'(rises_a - r0), 64'(v.exp_rises));
    chk({nm, "_rx_bytes"}, 64'(rx_a), 64'(v.dexp));
    chk({nm, "_busy_drops"}, 64'(drops), 64'd0);
    @(negedge clk);
    chk({nm, "_done_width"}, 64'(if_a.done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [3];
    int cs0, r0, drops, dt0, bad;
    bit ok;

    vecs[0] = '{BASIC,           56'h01FF3C80A55A0F, 504, 56};
    vecs[1] = '{56'h00000000000000, 56'h00000000000000, 504, 56};
    vecs[2] = '{56'h8001FE7FAA5581, 56'h8001FE7FAA5581, 504, 56};

    reset_a = 1'b1;
    reset_b = 1'b1;
    {if_a.start, if_a.mode_in, if_a.lint_in, if_a.color_idx_in, if_a.white_in,
     if_a.red_in, if_a.green_in, if_a.blue_in} = '0;
    {if_b.start, if_b.mode_in, if_b.lint_in, if_b.color_idx_in, if_b.white_in,
     if_b.red_in, if_b.green_in, if_b.blue_in} = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_cs",   64'(if_a.cs),   64'd1);
    chk("rst_sck",  64'(if_a.sck),  64'd0);
    chk("rst_mosi", 64'(if_a.mosi), 64'd0);
    chk("rst_busy", 64'(if_a.busy), 64'd0);
    chk("rst_done", 64'(if_a.done), 64'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 3; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Input latching: change red and re-strobe start mid-frame
    cs0 = cslow_a;
    start_a(BASIC);
    repeat (100) @(negedge clk);
    if_a.red_in = 8'h00;
    if_a.start  = 1'b1;
    @(negedge clk);
    if_a.start  = 1'b0;
    wait_done_a(ok, drops);
    chk("latch_done_seen", 64'(ok), 64'd1);
    chk("latch_rx_bytes", 64'(rx_a), 64'h01FF3C80A55A0F);
    chk("latch_busy_drops", 64'(drops), 64'd0);
    chk("latch_cs_low", 64'(cslow_a - cs0), 64'd504);
    repeat (20) @(negedge clk);
    chk("latch_no_second_frame", 64'(cslow_a - cs0), 64'd504);

    // Back-to-back: start asserted in the done cycle
    start_a(BASIC);
    wait_done_a(ok, drops);
    chk("b2b1_done_seen", 64'(ok), 64'd1);
    chk("b2b1_rx_bytes", 64'(rx_a), 64'h01FF3C80A55A0F);
    chk("b2b_cs_high_done_cycle", 64'(if_a.cs), 64'd1);
    cs0 = cslow_a;
    r0  = rises_a;
    start_a(ALL55);
    chk("b2b_cs_low_next_cycle", 64'(if_a.cs), 64'd0);
    wait_done_a(ok, drops);
    chk("b2b2_done_seen", 64'(ok), 64'd1);
    chk("b2b2_rx_bytes", 64'(rx_a), 64'h55555555555555);
    chk("b2b2_cs_low", 64'(cslow_a - cs0), 64'd504);
    chk("b2b2_sck_rises", 64'(rises_a - r0), 64'd56);
    repeat (2) @(negedge clk);

    // Reset during byte 3, bit 4 (sck high, mosi = 1)
    dt0 = done_total_a;
    start_a(RST_DATA);
    repeat (249) @(negedge clk);
    chk("pre_rst_cs",   64'(if_a.cs),   64'd0);
    chk("pre_rst_sck",  64'(if_a.sck),  64'd1);
    chk("pre_rst_mosi", 64'(if_a.mosi), 64'd1);
    reset_a = 1'b1;
    #1;
    chk("async_rst_cs",   64'(if_a.cs),   64'd1);
    chk("async_rst_sck",  64'(if_a.sck),  64'd0);
    chk("async_rst_mosi", 64'(if_a.mosi), 64'd0);
    chk("async_rst_busy", 64'(if_a.busy), 64'd0);
    repeat (3) @(negedge clk);
    reset_a = 1'b0;
    chk("rst_no_done", 64'(done_total_a - dt0), 64'd0);
    @(negedge clk);
    run_vec(vecs[0], "post_rst");

    // Parameter corner on instance b
    cs0 = cslow_b;
    r0  = rises_b;
    {if_b.mode_in, if_b.lint_in, if_b.color_idx_in, if_b.white_in,
     if_b.red_in, if_b.green_in, if_b.blue_in} = BASIC;
    if_b.start = 1'b1;
    @(negedge clk);
    if_b.start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (if_b.done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("div2_done_seen",   64'(ok), 64'd1);
    chk("div2_rx_bytes",    64'(rx_b), 64'h01FF3C80A55A0F);
    chk("div2_cs_low",      64'(cslow_b - cs0), 64'd228);
    chk("div2_sck_rises",   64'(rises_b - r0), 64'd56);
    chk("div2_setup_viol",  64'(setup_viol_b), 64'd0);
    chk("div2_period_viol", 64'(period_viol_b), 64'd0);

    // Idle integrity with toggling data inputs
    bad = 0;
    r0  = rises_a;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      {if_a.mode_in, if_a.lint_in, if_a.color_idx_in, if_a.white_in} = $urandom;
      {if_a.red_in, if_a.green_in, if_a.blue_in} = 24'($urandom);
      if (!if_a.cs || if_a.sck || if_a.mosi || if_a.busy || if_a.done) bad++;
    end
    chk("idle_outputs", 64'(bad), 64'd0);
    chk("idle_no_sck", 64'(rises_a - r0), 64'd0);
    chk("protocol_viol", 64'(prot_viol_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
